// File: rtl/inst_queue_if.sv
// inst_queue_if: fetch-side, decode-side and redirect signals of the instruction queue
interface inst_queue_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
);
    logic             in_valid;
    logic [WIDTH-1:0] in_pc;
    logic [WIDTH-1:0] in_instr;
    logic             in_adel;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_instr;
    logic             out_adel;
    logic             out_ready;
    logic             flush;
    logic             redirect;
    logic [PTR_W:0]   count;

    modport master (
        output in_valid, in_pc, in_instr, in_adel, out_ready, flush, redirect,
        input  in_ready, out_valid, out_pc, out_instr, out_adel, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, in_adel, out_ready, flush, redirect,
        output in_ready, out_valid, out_pc, out_instr, out_adel, count
    );
endinterface

// File: rtl/inst_queue.sv
// inst_queue: IF->ID instruction FIFO with full flush and delay-slot-preserving branch redirect
module inst_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input logic        clk,
    input logic        aresetn,
    inst_queue_if.slave q
);
    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
        logic             adel;
    } ent_t;

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    ent_t             mem_q [DEPTH];
    ent_t             head_ent;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   cnt_q, cnt_d, rem;
    logic             push, pop, wr;

    assign q.in_ready  = cnt_q != FULL;
    assign q.out_valid = cnt_q != '0;
    assign q.count     = cnt_q;
    assign head_ent    = mem_q[head_q];
    assign q.out_pc    = q.out_valid ? head_ent.pc : '0;
    assign q.out_instr = q.out_valid ? head_ent.instr : '0;
    assign q.out_adel  = q.out_valid & head_ent.adel;
    assign push        = q.in_valid & q.in_ready;
    assign pop         = q.out_valid & q.out_ready;
    assign rem         = cnt_q - (PTR_W+1)'(pop);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        wr     = 1'b0;
        if (q.flush) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else if (q.redirect) begin
            head_d = head_q + PTR_W'(pop);
            if (rem != '0) begin
                tail_d = head_d + PTR_W'(1);
                cnt_d  = (PTR_W+1)'(1);
            end else begin
                wr     = push;
                tail_d = tail_q + PTR_W'(push);
                cnt_d  = (PTR_W+1)'(push);
            end
        end else begin
            wr     = push;
            head_d = head_q + PTR_W'(pop);
            tail_d = tail_q + PTR_W'(push);
            cnt_d  = cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (aresetn && wr)
            mem_q[tail_q] <= '{pc: q.in_pc, instr: q.in_instr, adel: q.in_adel};
    end

    always_ff @(posedge clk) begin
        if (aresetn) begin
            assert (cnt_q <= FULL);
            assert (cnt_d <= FULL);
        end
    end
endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Instruction queue between the fetch stage and the decode stage.
- Buffers fetched {pc, instr, adel} entries so an ID stall does not hold fetch, and an IF cache miss does not starve ID while entries remain.
- Supports a full flush for exception/ERET redirect.
- Supports a branch redirect that keeps exactly one delay-slot entry and discards younger wrong-path entries.

Parameters:
- WIDTH, 32, data/address width of pc and instr fields.
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; count is PTR_W+1 bits.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- aresetn  in  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  in  1  IF presents a fetched instruction (IF not stalled, new PC).
- in_pc  in  WIDTH  PC of the fetched instruction.
- in_instr  in  WIDTH  fetched instruction word.
- in_adel  in  1  fetch address error flag (pc[1:0] != 0).
- in_ready  out  1  queue can accept; equals !full; drives IF stall.
- out_valid  out  1  head entry valid for ID.
- out_pc  out  WIDTH  head PC, 0 when out_valid=0.
- out_instr  out  WIDTH  head instruction, 0 when out_valid=0.
- out_adel  out  1  head address-error flag, 0 when out_valid=0.
- out_ready  in  1  ID consumes head this cycle (ID not stalled).
- flush  in  1  exception/ERET redirect: discard everything.
- redirect  in  1  branch/jump taken in ID: keep one delay-slot entry.
- count  out  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- **Reset** (aresetn=0 at posedge):
  - head_ptr=0, tail_ptr=0, count=0.
  - Storage need not be cleared.
  - Outputs: out_valid=0, out_pc/out_instr/out_adel=0, in_ready=1.
  - Reset overrides every other input in that cycle.
- **Push/pop:**
  - push = in_valid & in_ready; pop = out_valid & out_ready.
  - in_ready = (count != DEPTH). There is no push-when-full-with-pop, so there is no combinational path from out_ready to in_ready.
  - out_valid = (count != 0). out_* are driven from the head entry through combinational read of storage and masked to 0 when empty.
  - Latency: an entry pushed at edge N is visible at out_* after edge N (one cycle); there is no same-cycle bypass.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH; wrap-around must preserve FIFO order.
- **Priority** at each edge: reset > flush > redirect > normal push/pop.
- **flush=1:**
  - count=0, head_ptr=tail_ptr=0.
  - Same-cycle push and pop are discarded; the pop is still considered taken by ID.
- **redirect=1 and flush=0:** let R = count - pop, the entries remaining after the same-cycle pop.
  - R >= 1: keep only the oldest remaining entry (delay slot). count=1, head advances by pop, tail = new head + 1. Same-cycle push is discarded.
  - R == 0 and push: the pushed entry is the delay slot and is written. count=1.
  - R == 0 and no push: count=0. Exactly one subsequent push is accepted as the delay slot; the queue needs no extra state for this because IF has already been redirected.
- **adel:** travels with its entry unchanged; the queue never raises exceptions itself.
- **State:** implicit state is given by count, with regions empty (0), partial (1..DEPTH-1) and full (DEPTH).
  - Transitions are driven only by push, pop, flush and redirect as above.
  - count must never exceed DEPTH or underflow; assertions must check this.
- **Reset mid-operation:** all entries are lost and the queue behaves as just after reset on the next cycle.

Test Plan:
1. **Fill/drain:** reset, out_ready=0, push pc 0xbfc00000..0xbfc0000c (4 pushes) -> count=4, in_ready=0, 5th push ignored. Then out_ready=1 -> out_pc 0xbfc00000,04,08,0c in order, then out_valid=0 and out_pc=0.
2. **Wrap + simultaneous:** keep count=2 while pushing and popping every cycle for 10 cycles with pc incrementing by 4 -> count stays 2, output PCs strictly sequential across pointer wrap.
3. **Flush:** count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1, pushed pc never appears.
4. **Redirect with backlog:** entries A,B,C (pc 0x100,0x104,0x108), redirect=1 with out_ready=1 and push D -> next cycle count=1, out_pc=0x104; C and D never appear.
5. **Redirect empty queue:** count=1 (A), redirect with out_ready=1 and push B(0x104) -> count=1, out_pc=0x104. Repeat with no push -> count=0, next push 0x104 appears normally.
6. **Reset/adel:** push entry with in_adel=1 pc=0xbfc00001 -> out_adel=1 with that pc. Assert aresetn=0 mid-stream with count=3 -> next cycle count=0, out_valid=0, out_adel=0.
